flags_register_stack: RTL
=========================

Name: flags_register_stack

Overview:
Parametrised successor to the CPU's 2-bit flags register, sitting between the ALU flag outputs and the control unit. It holds FLAG_W status flags with masked load plus per-bit set/clear. It also has a hardware save/restore stack of STACK_DEPTH entries. The control unit pushes flags on interrupt/call entry and pops them on return.

Parameters:
FLAG_W, 4, number of flag bits (bit 0 = Zero, bit 1 = Carry, higher bits are user-defined).
STACK_DEPTH, 4, number of saved-flag entries, ≥1. The pointer width is a derived localparam, clog2(STACK_DEPTH+1).

Ports:
Clk  input  1  system clock, all state updates on rising edge.
Rst  input  1  synchronous active-high reset.
FlagsRegIn  input  1  masked load enable.
FlagsMask  input  FLAG_W  load mask; 1 = bit takes ALUFlagsIn.
ALUFlagsIn  input  FLAG_W  flag values from ALU.
FlagSet  input  FLAG_W  per-bit set strobe.
FlagClr  input  FLAG_W  per-bit clear strobe.
Push  input  1  save current Flags to stack.
Pop  input  1  restore Flags from stack top.
ErrClr  input  1  clear sticky error bits.
Flags  output  FLAG_W  current flag register.
Depth  output  clog2(STACK_DEPTH+1)  number of valid stack entries.
Empty  output  1  Depth == 0.
Full  output  1  Depth == STACK_DEPTH.
Overflow  output  1  sticky: a Push was attempted while Full.
Underflow  output  1  sticky: a Pop was attempted while Empty.

Behaviour:
- Reset: Clk and Rst are a single synchronous domain. When Rst is high at a rising edge, the next state is: Flags = 0, Depth = 0, Overflow = 0, Underflow = 0, so Empty = 1 and Full = 0. Stack RAM contents are not reset. Rst overrides every other input, including a Push or Pop issued in the same cycle. A save in progress is simply discarded.
- All outputs are registered or derived from registers. Effects appear one cycle after the inputs are sampled. No combinational input-to-output paths.
- Next-flags computation, applied in this order:
  (1) base = Flags_q.
  (2) If a pop is effective, base = stack[top].
  (3) If FlagsRegIn, base = (base & ~FlagsMask) | (ALUFlagsIn & FlagsMask).
  (4) base |= FlagSet.
  (5) base &= ~FlagClr.
  Clear wins over set; set wins over load; explicit writes win over the popped value.
- Push alone, not Full: stack[Depth] = Flags_q (value before this cycle's writes), Depth + 1.
- Push alone, Full: nothing is stored, Depth unchanged, Overflow = 1.
- Pop alone, not Empty: effective pop, Depth − 1.
- Pop alone, Empty: Flags follows steps 1 and 3–5 only, Depth unchanged, Underflow = 1.
- Push and Pop together, not Empty (exchange): stack[Depth−1] = Flags_q and step 2 uses the old top entry. Depth unchanged. No error, even when Full.
- Push and Pop together, Empty: behaves as Push alone, and Underflow = 1.
- ErrClr clears both sticky bits. If an error event occurs in the same cycle, the set takes priority.
- Depth never wraps. It saturates at 0 and at STACK_DEPTH via the rules above.
- With Push, Pop and FlagSet/FlagClr all idle and FlagsMask all-ones, behaviour is identical to the legacy flags register.

Decomposition:
- Shared CPU package holds:
  - flag bit index constants: FLAG_Z = 0, FLAG_C = 1;
  - default FLAG_W;
  - a flags_t typedef of width FLAG_W.
- One natural sub-module, flags_lifo: a STACK_DEPTH × FLAG_W register-array LIFO with push/pop/exchange, Depth, Full and Empty. The top level keeps the flag-update logic and the sticky error bits.

Test Plan (FLAG_W=4, STACK_DEPTH=2):
1. Reset then idle. Rst = 1 for 1 cycle with Push = 1 → Flags = 0000, Depth = 0, Empty = 1, Overflow = Underflow = 0.
2. Masked load and set/clear. Flags = 0000; FlagsRegIn = 1, FlagsMask = 0011, ALUFlagsIn = 1111, FlagSet = 1000, FlagClr = 0001 → next Flags = 1010.
3. Push, push, overflow. Flags = 0101, Push → Depth = 1. Set Flags = 0110, Push → Depth = 2, Full = 1. Push → Overflow = 1, Depth = 2.
4. Pop chain and underflow, continuing from 3. Pop → Flags = 0110, Depth = 1. Pop → Flags = 0101, Depth = 0. Pop → Underflow = 1, Flags = 0101. Then ErrClr → both errors = 0.
5. Push with same-cycle write. Flags = 0011; Push with FlagsRegIn = 1, FlagsMask = 1111, ALUFlagsIn = 1100 → Flags = 1100, stack top = 0011. Then Pop → Flags = 0011.
6. Exchange at Full. Stack holds 0001 (bottom) and 0010 (top), Flags = 0100; Push + Pop → Flags = 0010, top = 0100, Depth = 2, no Overflow. Separately, ErrClr coinciding with a failing Pop → Underflow stays 1.

Source files
------------

// File: rtl/flags_register_stack_pkg.sv
// Shared CPU flag definitions: bit indices, default width, flag word type and
// the helper that sizes the save-stack depth pointer.
package flags_register_stack_pkg;

   localparam int FLAG_Z         = 0;
   localparam int FLAG_C         = 1;
   localparam int FLAG_W_DEFAULT = 4;

   typedef logic [FLAG_W_DEFAULT-1:0] flags_t;

   // Pointer must represent 0..depth inclusive, hence depth+1 states.
   function automatic int ptr_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/flags_register_stack_if.sv
// Control-unit <-> flags register bundle: ALU/control strobes in, registered
// flag state, stack depth and sticky error bits out.
interface flags_register_stack_if
   import flags_register_stack_pkg::*;
#(
   parameter int FLAG_W      = FLAG_W_DEFAULT,
   parameter int STACK_DEPTH = 4
) ();

   localparam int PTR_W = ptr_width(STACK_DEPTH);

   logic              FlagsRegIn;
   logic [FLAG_W-1:0] FlagsMask;
   logic [FLAG_W-1:0] ALUFlagsIn;
   logic [FLAG_W-1:0] FlagSet;
   logic [FLAG_W-1:0] FlagClr;
   logic              Push;
   logic              Pop;
   logic              ErrClr;
   logic [FLAG_W-1:0] Flags;
   logic [PTR_W-1:0]  Depth;
   logic              Empty;
   logic              Full;
   logic              Overflow;
   logic              Underflow;

   modport master (
      output FlagsRegIn, FlagsMask, ALUFlagsIn, FlagSet, FlagClr,
      output Push, Pop, ErrClr,
      input  Flags, Depth, Empty, Full, Overflow, Underflow
   );

   modport slave (
      input  FlagsRegIn, FlagsMask, ALUFlagsIn, FlagSet, FlagClr,
      input  Push, Pop, ErrClr,
      output Flags, Depth, Empty, Full, Overflow, Underflow
   );

endinterface

// File: rtl/flags_register_stack_lifo.sv
// Register-array LIFO for saved flag words, supporting push, pop and a
// same-cycle exchange of the top entry.
module flags_lifo
   import flags_register_stack_pkg::*;
#(
   parameter int W     = FLAG_W_DEFAULT,
   parameter int DEPTH = 4,
   parameter int PTR_W = ptr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [W-1:0]     wdata_i,
   output logic [W-1:0]     top_o,
   output logic             pop_eff_o,
   output logic             overflow_o,
   output logic             underflow_o,
   output logic [PTR_W-1:0] depth_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [PTR_W-1:0] depth_q, depth_d;
   logic [PTR_W-1:0] top_idx;
   logic [PTR_W-1:0] wr_idx;
   logic [W-1:0]     entry [DEPTH];
   logic             empty, full, exchange, do_push, do_pop, wr_en;

   assign empty = (depth_q == '0);
   assign full  = (depth_q == PTR_W'(DEPTH));

   // Exchange only applies with something to swap; push+pop on empty is a plain push.
   assign exchange = push_i & pop_i & ~empty;
   assign do_push  = push_i & ~exchange & ~full;
   assign do_pop   = pop_i & ~push_i & ~empty;
   assign wr_en    = exchange | do_push;
   assign top_idx  = depth_q - PTR_W'(1);
   assign wr_idx   = exchange ? top_idx : depth_q;

   always_comb begin
      depth_d = depth_q;
      if (do_push)
         depth_d = depth_q + PTR_W'(1);
      else if (do_pop)
         depth_d = depth_q - PTR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (srst)
         depth_q <= '0;
      else
         depth_q <= depth_d;
   end

   // Entries are deliberately not reset; only depth_q defines what is valid.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [W-1:0] entry_q;
      always_ff @(posedge clk) begin
         if (wr_en && (wr_idx == PTR_W'(gi)))
            entry_q <= wdata_i;
      end
      assign entry[gi] = entry_q;
   end

   always_comb begin
      top_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (top_idx == PTR_W'(i))
            top_o = entry[i];
      end
   end

   assign pop_eff_o   = pop_i & ~empty;
   assign overflow_o  = push_i & ~pop_i & full;
   assign underflow_o = pop_i & empty;
   assign depth_o     = depth_q;
   assign full_o      = full;
   assign empty_o     = empty;

endmodule

// File: rtl/flags_register_stack.sv
// CPU status flags with masked load, per-bit set/clear, a save/restore stack
// and sticky overflow/underflow indicators.
module flags_register_stack
   import flags_register_stack_pkg::*;
#(
   parameter int FLAG_W      = FLAG_W_DEFAULT,
   parameter int STACK_DEPTH = 4
) (
   input  logic                  Clk,
   input  logic                  Rst,
   flags_register_stack_if.slave bus
);

   localparam int PTR_W = ptr_width(STACK_DEPTH);

   logic [FLAG_W-1:0] flags_q, flags_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic [FLAG_W-1:0] stack_top;
   logic              pop_eff, ovf_ev, udf_ev;
   logic [PTR_W-1:0]  depth;
   logic              full, empty;

   flags_lifo #(
      .W     (FLAG_W),
      .DEPTH (STACK_DEPTH),
      .PTR_W (PTR_W)
   ) u_lifo (
      .clk         (Clk),
      .srst        (Rst),
      .push_i      (bus.Push),
      .pop_i       (bus.Pop),
      .wdata_i     (flags_q),
      .top_o       (stack_top),
      .pop_eff_o   (pop_eff),
      .overflow_o  (ovf_ev),
      .underflow_o (udf_ev),
      .depth_o     (depth),
      .full_o      (full),
      .empty_o     (empty)
   );

   // Precedence: popped value < masked load < set < clear.
   always_comb begin
      flags_d = flags_q;
      if (pop_eff)
         flags_d = stack_top;
      if (bus.FlagsRegIn)
         flags_d = (flags_d & ~bus.FlagsMask) | (bus.ALUFlagsIn & bus.FlagsMask);
      flags_d = (flags_d | bus.FlagSet) & ~bus.FlagClr;
   end

   // A new error event beats a coincident ErrClr.
   always_comb begin
      ovf_d = ovf_ev | (ovf_q & ~bus.ErrClr);
      udf_d = udf_ev | (udf_q & ~bus.ErrClr);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         flags_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         flags_q <= flags_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   assign bus.Flags     = flags_q;
   assign bus.Depth     = depth;
   assign bus.Empty     = empty;
   assign bus.Full      = full;
   assign bus.Overflow  = ovf_q;
   assign bus.Underflow = udf_q;

endmodule
